// File: rtl/demux_pkg.sv
// demux_pkg: shared state encoding and sizing helpers for the demux select sequencer.
package demux_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, DRIVE} state_e;
  localparam int SEL_W_DEF = 3;
  localparam int NUM_CH = 2 ** SEL_W_DEF;
  localparam int REQ_W = SEL_W_DEF + 1;
  function automatic int req_w(input int sel_w);
    return sel_w + 1;
  endfunction
  function automatic int cnt_w(input int settle, input int hold);
    return $clog2((settle > hold ? settle : hold) + 1);
  endfunction
endpackage

// File: rtl/demux_sel_sequencer_fifo.sv
// demux_req_fifo: synchronous request FIFO with full/empty flags and sync active-high reset.
module demux_req_fifo
  import demux_pkg::*;
#(
  parameter int W = REQ_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign rdata_o = mem_q[rp_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end
endmodule

// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer: buffers (dest,data) requests and plays them onto a demux with settle/hold phases.
// Optional DEMUX_SEQ_AUTO_EN: ignore s_dest and scan channels round-robin from an internal pointer.
module demux_sel_sequencer
  import demux_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [SEL_W-1:0] s_dest,
  input  logic             s_data,
  output logic [SEL_W-1:0] sel,
  output logic             din,
  output logic             drive_en,
  output logic             busy
);
  localparam int RW = req_w(SEL_W);
  localparam int CW = cnt_w(SETTLE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d, src_sel;
  logic data_q, data_d, din_q, din_d, de_q, de_d;
  logic full, empty, pop;
  logic [RW-1:0] rdata;
  demux_req_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s_valid && s_ready),
    .pop_i   (pop),
    .wdata_i ({s_dest, s_data}),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );
`ifdef DEMUX_SEQ_AUTO_EN
  logic [SEL_W-1:0] ptr_q;
  assign src_sel = ptr_q;
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else if (state_q == DRIVE && state_d == IDLE) ptr_q <= ptr_q + SEL_W'(1);
  end
`else
  assign src_sel = rdata[RW-1:1];
`endif
  assign s_ready = !rst && !full;
  assign busy = state_q != IDLE || !empty;
  assign sel = sel_q;
  assign din = din_q;
  assign drive_en = de_q;
  // sel is only ever loaded on the IDLE->SETTLE step, so it cannot move while data is driven.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    data_d = data_q;
    din_d = din_q;
    de_d = de_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        sel_d = src_sel;
        data_d = rdata[0];
        cnt_d = SETTLE_LD;
        state_d = SETTLE;
      end
      SETTLE: if (cnt_q == '0) begin
        din_d = data_q;
        de_d = 1'b1;
        cnt_d = HOLD_LD;
        state_d = DRIVE;
      end else cnt_d = cnt_q - CW'(1);
      DRIVE: if (cnt_q == '0) begin
        din_d = 1'b0;
        de_d = 1'b0;
        cnt_d = '0;
        state_d = IDLE;
      end else cnt_d = cnt_q - CW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sel_q <= '0;
      data_q <= 1'b0;
      din_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      data_q <= data_d;
      din_q <= din_d;
      de_q <= de_d;
    end
  end
endmodule

// File: tb/tb_demux_sel_sequencer.sv
// tb_demux_sel_sequencer: scoreboard bench for demux_sel_sequencer (default parameters).
module tb_demux_sel_sequencer;
  localparam int HOLD = 2;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, s_data = 1'b0;
  logic [2:0] s_dest = '0;
  logic s_ready, din, drive_en, busy;
  logic [2:0] sel;
  int n_cmp = 0, n_bad = 0, cyc = 0, n_drv = 0, hold_n = 0, last_rise = -1;
  logic [3:0] exp_q[$];
  int acc_q[$];
  logic [2:0] exp_ptr = '0, sel_r = '0;
  logic [3:0] last_exp = '0, item = '0;
  logic de_prev = 1'b0, din_r = 1'b0, acc;
  bit spacing_on = 1'b0;

  demux_sel_sequencer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_dest(s_dest),
    .s_data(s_data), .sel(sel), .din(din), .drive_en(drive_en), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] d, input logic b, output logic a);
    logic [3:0] e;
    s_valid = v;
    s_dest = d;
    s_data = b;
    a = v && s_ready;
`ifdef DEMUX_SEQ_AUTO_EN
    e = {exp_ptr, b};
`else
    e = {d, b};
`endif
    if (a) begin
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      last_exp = e;
      exp_ptr = exp_ptr + 3'd1;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] d, input logic b);
    logic a = 1'b0;
    for (int t = 0; t < 50 && !a; t++) step(1'b1, d, b, a);
    check("send_accepted", a, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (exp_q.size() != 0 || busy); t++) @(negedge clk);
    check("drain", exp_q.size() + busy, 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      de_prev = 1'b0;
      hold_n = 0;
      last_rise = -1;
    end else begin
      if (drive_en && !de_prev) begin
        check("sb_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          item = exp_q.pop_front();
          check("drv_sel", sel, item[3:1]);
          check("drv_din", din, item[0]);
        end
        if (spacing_on && last_rise >= 0) check("spacing", cyc - last_rise, 4);
        last_rise = cyc;
        sel_r = sel;
        din_r = din;
        hold_n = 1;
        n_drv++;
      end else if (drive_en) begin
        check("sel_stable", sel, sel_r);
        check("din_stable", din, din_r);
        hold_n++;
      end else begin
        if (de_prev) check("hold_len", hold_n, HOLD);
        check("din_idle", din, 0);
      end
      de_prev = drive_en;
    end
  end

  initial begin
    int d0;
    @(negedge clk);
    // reset held with s_valid asserted: nothing may be accepted
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd7, 1'b1, acc);
      check("rst_acc", acc, 0);
      check("rst_sel", sel, 0);
      check("rst_din", din, 0);
      check("rst_de", drive_en, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", s_ready, 0);
    end
    exp_q.delete();
    exp_ptr = '0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", s_ready, 1);

    // single request latency
    step(1'b1, 3'd5, 1'b1, acc);
    check("t2_acc", acc, 1);
    @(negedge clk);
    check("t2_sel", sel, last_exp[3:1]);
    check("t2_settle_din", din, 0);
    check("t2_settle_de", drive_en, 0);
    check("t2_busy", busy, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t2_hold_din", din, 1);
      check("t2_hold_de", drive_en, 1);
    end
    @(negedge clk);
    check("t2_end_de", drive_en, 0);
    check("t2_end_din", din, 0);
    check("t2_end_busy", busy, 0);

    // back-to-back burst with backpressure
    acc_q.delete();
    d0 = n_drv;
    last_rise = -1;
    spacing_on = 1'b1;
    for (int i = 0; i < 8; i++) send(3'(i), 1'(i));
    check("t3_n_acc", acc_q.size(), 8);
    if (acc_q.size() == 8) begin
      check("t3_first5", acc_q[4] - acc_q[0], 4);
      check("t3_stall", acc_q[5] - acc_q[4], 2);
      check("t3_pace", acc_q[6] - acc_q[5], 4);
    end
    drain();
    spacing_on = 1'b0;
    check("t3_drives", n_drv - d0, 8);

    // reset during DRIVE with two requests queued
    send(3'd3, 1'b1);
    send(3'd4, 1'b0);
    send(3'd6, 1'b1);
    for (int t = 0; t < 20 && !drive_en; t++) @(negedge clk);
    check("t4_in_drive", drive_en, 1);
    rst = 1'b1;
    exp_q.delete();
    exp_ptr = '0;
    @(negedge clk);
    check("t4_sel", sel, 0);
    check("t4_din", din, 0);
    check("t4_de", drive_en, 0);
    check("t4_busy", busy, 0);
    check("t4_ready", s_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t4_fifo_empty", busy, 0);
    check("t4_ready_back", s_ready, 1);
    d0 = n_drv;
    repeat (10) @(negedge clk);
    check("t4_no_replay", n_drv - d0, 0);

`ifdef DEMUX_SEQ_AUTO_EN
    // round-robin scan ignores s_dest and wraps
    d0 = n_drv;
    for (int i = 0; i < 10; i++) send(3'd6, 1'(i));
    drain();
    check("t5_drives", n_drv - d0, 10);
`endif

    // push on the pop edge with three entries queued
    d0 = n_drv;
    step(1'b1, 3'd1, 1'b0, acc);
    step(1'b1, 3'd2, 1'b1, acc);
    step(1'b1, 3'd3, 1'b0, acc);
    step(1'b1, 3'd4, 1'b1, acc);
    step(1'b0, 3'd0, 1'b0, acc);
    check("t6_ready_at3", s_ready, 1);
    step(1'b1, 3'd5, 1'b1, acc);
    check("t6_push_on_pop", acc, 1);
    check("t6_still3", s_ready, 1);
    step(1'b1, 3'd6, 1'b0, acc);
    check("t6_push4", acc, 1);
    check("t6_full", s_ready, 0);
    drain();
    check("t6_drives", n_drv - d0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
